// File: rtl/cpu_clock_controller.sv
// cpu_clock_controller: RUN/STEP/HALT clock-enable generator for the core; optional breakpoint via CPU_CLOCK_CONTROLLER_BREAKPOINT_EN
module cpu_clock_controller #(
  parameter int DIV_WIDTH       = 26,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [1:0]           mode_sel,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 step_key,
  output logic                 cpu_en,
  output logic [CNT_WIDTH-1:0] tick_count,
  output logic [1:0]           state
`ifdef CPU_CLOCK_CONTROLLER_BREAKPOINT_EN
  ,
  input  logic [31:0]          pc_in,
  input  logic [31:0]          bp_addr,
  input  logic                 bp_valid
`endif
);
  localparam logic [1:0] HALT = 2'b00, RUN = 2'b01, STEP = 2'b10, BRK = 2'b11;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] state_q, state_d, mode_state;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, per_q, per_d;
  logic [CNT_WIDTH-1:0] tick_q, tick_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic cpu_en_q, cpu_en_d, s1_q, s1_d, s2_q, s2_d, deb_q, deb_d, step_req_q, step_req_d;
  logic tc;
  assign mode_state = mode_sel == 2'b10 ? STEP : mode_sel == 2'b00 ? HALT : RUN;
  assign tc = cnt_q == ((per_q > DIV_WIDTH'(1)) ? per_q - DIV_WIDTH'(1) : '0);
  assign cpu_en = cpu_en_q;
  assign tick_count = tick_q;
  assign state = state_q;
  // all registers, synchronous reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= HALT;
      cnt_q      <= '0;
      per_q      <= '0;
      tick_q     <= '0;
      dcnt_q     <= '0;
      cpu_en_q   <= 1'b0;
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      deb_q      <= 1'b1;
      step_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      tick_q     <= tick_d;
      dcnt_q     <= dcnt_d;
      cpu_en_q   <= cpu_en_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_q      <= deb_d;
      step_req_q <= step_req_d;
    end
  end
  // next state: follow mode_sel, except BREAK holds while RUN stays selected
  always_comb begin
    state_d = mode_state;
`ifdef CPU_CLOCK_CONTROLLER_BREAKPOINT_EN
    if (state_q == BRK && mode_state == RUN) state_d = BRK;
    if (state_q == RUN && mode_state == RUN && tc && bp_valid && pc_in == bp_addr) state_d = BRK;
`endif
  end
  // key debounce, period counter and enable pulse generation
  always_comb begin
    s1_d   = step_key;
    s2_d   = s1_q;
    deb_d  = deb_q;
    dcnt_d = '0;
    if (s2_q != deb_q) begin
      if (dcnt_q + DW'(1) == DW'(DEBOUNCE_CYCLES)) deb_d = s2_q;
      else dcnt_d = dcnt_q + DW'(1);
    end
    step_req_d = deb_q & ~deb_d;
    cnt_d    = '0;
    per_d    = per_q;
    cpu_en_d = 1'b0;
    if (state_q == RUN && state_d == RUN) begin
      if (tc) begin
        per_d    = div_value;
        cpu_en_d = 1'b1;
      end else cnt_d = cnt_q + DIV_WIDTH'(1);
    end else if (state_d == RUN) per_d = div_value;
    if (state_q == STEP && state_d == STEP && step_req_q) cpu_en_d = 1'b1;
    tick_d = tick_q + CNT_WIDTH'(cpu_en_d);
  end
endmodule
